// File: rtl/line_buffer_3row.sv
// Two-line raster buffer feeding a 3x3 convolver: emits column triples (y-2, y-1, y).
// Optional macro BORDER_REPLICATE_EN also emits during the two fill lines (top-border replication).
module line_buffer_3row #(
  parameter int IMG_WIDTH = 640,
  parameter int DATA_W    = 8,
  parameter int COL_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] pix_i,
  input  logic              pix_valid_i,
  input  logic              sof_i,
  output logic [DATA_W-1:0] fifo1_data_o,
  output logic [DATA_W-1:0] fifo2_data_o,
  output logic [DATA_W-1:0] fifo3_data_o,
  output logic              ready_o,
  output logic              eol_o
);

  typedef enum logic [1:0] {FILL0, FILL1, STREAM} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  state_t            state, state_next, state_eff;
  logic [COL_W-1:0]  col, col_next, col_eff;
  logic              at_last;
  logic              emit;

  logic [DATA_W-1:0] line_a [IMG_WIDTH];
  logic [DATA_W-1:0] line_b [IMG_WIDTH];

  // A start-of-frame pixel is processed as row 0, column 0 of a fresh fill.
  always_comb begin
    state_eff  = state;
    col_eff    = col;
    if (pix_valid_i && sof_i) begin
      state_eff = FILL0;
      col_eff   = '0;
    end
    at_last    = (col_eff == LAST_COL);

    state_next = state;
    col_next   = col;
    if (pix_valid_i) begin
      state_next = state_eff;
      col_next   = at_last ? '0 : col_eff + COL_W'(1);
      if (at_last) begin
        case (state_eff)
          FILL0:   state_next = FILL1;
          FILL1:   state_next = STREAM;
          default: state_next = STREAM;
        endcase
      end
    end

`ifdef BORDER_REPLICATE_EN
    emit = pix_valid_i;
`else
    emit = pix_valid_i && (state_eff == STREAM);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL0;
      col   <= '0;
    end else begin
      state <= state_next;
      col   <= col_next;
    end
  end

  // Line storage: not reset, contents are refilled by every frame before use.
  always_ff @(posedge clk) begin
    if (pix_valid_i && !rst) begin
      line_a[col_eff] <= line_b[col_eff];
      line_b[col_eff] <= pix_i;
    end
  end

  // Registered read of the pre-write line contents; data holds while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo1_data_o <= '0;
      fifo2_data_o <= '0;
      fifo3_data_o <= '0;
      ready_o      <= 1'b0;
      eol_o        <= 1'b0;
    end else begin
      ready_o <= emit;
      eol_o   <= emit && at_last;
      if (emit) begin
        fifo3_data_o <= pix_i;
        case (state_eff)
          FILL0: begin
            fifo1_data_o <= pix_i;
            fifo2_data_o <= pix_i;
          end
          FILL1: begin
            fifo1_data_o <= line_b[col_eff];
            fifo2_data_o <= line_b[col_eff];
          end
          default: begin
            fifo1_data_o <= line_a[col_eff];
            fifo2_data_o <= line_b[col_eff];
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_line_buffer_3row.sv
// Randomised and directed bench for line_buffer_3row (IMG_WIDTH=4), frame-queue reference model.
// Honours BORDER_REPLICATE_EN when the design is built with it.
module tb_line_buffer_3row;
  localparam int W  = 4;
  localparam int DW = 8;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] pix_i;
  logic          pix_valid_i;
  logic          sof_i;
  logic [DW-1:0] fifo1_data_o, fifo2_data_o, fifo3_data_o;
  logic          ready_o, eol_o;

  line_buffer_3row #(.IMG_WIDTH(W), .DATA_W(DW), .COL_W(CW)) dut (
    .clk(clk), .rst(rst), .pix_i(pix_i), .pix_valid_i(pix_valid_i), .sof_i(sof_i),
    .fifo1_data_o(fifo1_data_o), .fifo2_data_o(fifo2_data_o), .fifo3_data_o(fifo3_data_o),
    .ready_o(ready_o), .eol_o(eol_o)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: every pixel of the current frame in raster order.
  logic [DW-1:0] frame_q[$];
  logic [DW-1:0] e1 = '0, e2 = '0, e3 = '0;
  logic          er = 1'b0, ee = 1'b0;
  logic [3*DW+1:0] got, expv;

  task automatic model_reset();
    frame_q.delete();
    e1 = '0; e2 = '0; e3 = '0; er = 1'b0; ee = 1'b0;
  endtask

  // Drives one cycle, then leaves expectations for that cycle in e1/e2/e3/er/ee.
  task automatic step(input logic v, input logic s, input logic [DW-1:0] p);
    int idx, row, c;
    pix_valid_i = v; sof_i = s; pix_i = p;
    @(posedge clk); #1;
    er = 1'b0; ee = 1'b0;
    if (v) begin
      if (s) frame_q.delete();
      frame_q.push_back(p);
      idx = frame_q.size() - 1;
      row = idx / W;
      c   = idx % W;
`ifdef BORDER_REPLICATE_EN
      er = 1'b1; e3 = p;
      if (row == 0) begin e1 = p; e2 = p; end
      else if (row == 1) begin e1 = frame_q[idx-W]; e2 = frame_q[idx-W]; end
      else begin e1 = frame_q[idx-2*W]; e2 = frame_q[idx-W]; end
`else
      if (row >= 2) begin
        er = 1'b1; e1 = frame_q[idx-2*W]; e2 = frame_q[idx-W]; e3 = p;
      end
`endif
      ee = er && (c == W-1);
    end
    pix_valid_i = 1'b0; sof_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_valid_i = 1'b0; sof_i = 1'b0; pix_i = '0;
    @(posedge clk); #1;
    got = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
    total++;
    if (got !== '0) begin bad++; $display("FAIL reset_state got=%h exp=0", got); end
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 12; i++) step(1'b1, i == 1, DW'(i + 40));
    #2 rst = 1'b1;
    #1;
    got = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
    total++;
    if (got !== '0) begin bad++; $display("FAIL async_reset got=%h exp=0", got); end
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0, DW'($urandom));
      got  = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
      expv = {e1, e2, e3, er, ee};
      total++;
      if (got !== expv) begin bad++; $display("FAIL after_reset px=%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_frame();
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, i == 1, DW'(i));
      got  = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
      expv = {e1, e2, e3, er, ee};
      total++;
      if (got !== expv) begin bad++; $display("FAIL frame px=%0d got=%h exp=%h", i, got, expv); end
    end
`ifndef BORDER_REPLICATE_EN
    total++;
    if ({fifo1_data_o, fifo2_data_o, fifo3_data_o, eol_o} !== {8'd4, 8'd8, 8'd12, 1'b1}) begin
      bad++;
      $display("FAIL last_column got=%0d,%0d,%0d eol=%0b exp=4,8,12 eol=1",
               fifo1_data_o, fifo2_data_o, fifo3_data_o, eol_o);
    end
`endif
  endtask

  task automatic test_gaps();
    for (int i = 1; i <= 12; i++) begin
      for (int g = 0; g < 2; g++) begin
        if (g == 0) step(1'b1, i == 1, DW'(i));
        else        step(1'b0, 1'b1, DW'($urandom));
        got  = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
        expv = {e1, e2, e3, er, ee};
        total++;
        if (got !== expv) begin bad++; $display("FAIL gaps px=%0d idle=%0d got=%h exp=%h", i, g, got, expv); end
      end
    end
  endtask

  task automatic test_row_shift();
    for (int i = 13; i <= 16; i++) begin
      step(1'b1, 1'b0, DW'(i));
      got  = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
      expv = {e1, e2, e3, er, ee};
      total++;
      if (got !== expv) begin bad++; $display("FAIL row_shift px=%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_sof_restart();
    // New frame right after a full line, then a second restart in mid-line.
    for (int i = 0; i < 18; i++) begin
      step(1'b1, (i == 0) || (i == 14), (i == 0) ? 8'd100 : DW'($urandom));
      got  = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
      expv = {e1, e2, e3, er, ee};
      total++;
      if (got !== expv) begin bad++; $display("FAIL sof_restart px=%0d got=%h exp=%h", i, got, expv); end
    end
  endtask

  task automatic test_random();
    logic v, s;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      s = ($urandom_range(0, 39) == 0);
      step(v, s, DW'($urandom));
      got  = {fifo1_data_o, fifo2_data_o, fifo3_data_o, ready_o, eol_o};
      expv = {e1, e2, e3, er, ee};
      total++;
      if (got !== expv) begin bad++; $display("FAIL random cyc=%0d v=%0b s=%0b got=%h exp=%h", i, v, s, got, expv); end
    end
  endtask

  initial begin
    rst = 1'b1; pix_valid_i = 1'b0; sof_i = 1'b0; pix_i = '0;
    test_reset();
    test_frame();
    test_gaps();
    test_row_shift();
    test_sof_restart();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
